// File: rtl/apple1_bus_pkg.sv
// Shared types, constants and parameter-field helpers for the Apple-1 bus controller.
package apple1_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } bus_state_t;

    localparam logic [7:0] DATA_IDLE = 8'hFF;

    // Wide enough to hold any packed per-slot parameter vector we expect to see.
    localparam int unsigned FIELD_BUS_W = 1024;

    function automatic logic [31:0] slot_field(
        input logic [FIELD_BUS_W-1:0] packed_v,
        input int unsigned            width,
        input int unsigned            idx
    );
        logic [FIELD_BUS_W-1:0] shifted;
        shifted = packed_v >> (width * idx);
        return shifted[31:0] & ((32'd1 << width) - 32'd1);
    endfunction

    function automatic logic [3:0] slot_wait(
        input logic [FIELD_BUS_W-1:0] packed_v,
        input int unsigned            idx
    );
        return 4'(slot_field(packed_v, 4, idx));
    endfunction

endpackage

// File: rtl/apple1_addr_decode.sv
// Combinational priority decoder: lowest-numbered matching slot wins, no match means RAM.
module apple1_addr_decode
    import apple1_bus_pkg::*;
#(
    parameter int                          NUM_SLOTS = 4,
    parameter int                          ADDR_W    = 16,
    parameter logic [NUM_SLOTS*ADDR_W-1:0] SLOT_BASE = {16'hD010, 16'hD012, 16'hF000, 16'hC000},
    parameter logic [NUM_SLOTS*ADDR_W-1:0] SLOT_MASK = {16'hFFFE, 16'hFFFE, 16'hFFF8, 16'hFF00},
    localparam int                         IDX_W     = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1
) (
    input  logic [ADDR_W-1:0]    addr,
    output logic                 hit,
    output logic [IDX_W-1:0]     idx,
    output logic [NUM_SLOTS-1:0] onehot
);

    logic [NUM_SLOTS-1:0] match;

    for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_match
        localparam logic [ADDR_W-1:0] BASE = ADDR_W'(slot_field(FIELD_BUS_W'(SLOT_BASE), ADDR_W, gi));
        localparam logic [ADDR_W-1:0] MASK = ADDR_W'(slot_field(FIELD_BUS_W'(SLOT_MASK), ADDR_W, gi));
        assign match[gi]  = ((addr & MASK) == BASE);
        assign onehot[gi] = hit && (idx == IDX_W'(gi));
    end

    // Scan from the top down so the lowest matching index is the last one written.
    always_comb begin
        hit = 1'b0;
        idx = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (match[i]) begin
                hit = 1'b1;
                idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/apple1_bus_ctrl.sv
// CPU-side bus controller: fast targets answer combinationally, slow slots stall the CPU
// through a latched WAIT/DONE handshake with wait states, optional ack and a timeout.
module apple1_bus_ctrl
    import apple1_bus_pkg::*;
#(
    parameter int                          NUM_SLOTS = 4,
    parameter int                          ADDR_W    = 16,
    parameter int                          DATA_W    = 8,
    parameter logic [NUM_SLOTS*ADDR_W-1:0] SLOT_BASE = {16'hD010, 16'hD012, 16'hF000, 16'hC000},
    parameter logic [NUM_SLOTS*ADDR_W-1:0] SLOT_MASK = {16'hFFFE, 16'hFFFE, 16'hFFF8, 16'hFF00},
    parameter logic [NUM_SLOTS*4-1:0]      SLOT_WAIT = {4'd0, 4'd0, 4'd0, 4'd3},
    parameter logic [NUM_SLOTS-1:0]        SLOT_ACK  = 4'b0000,
    parameter int                          TIMEOUT   = 64,
    localparam int                         IDX_W     = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1,
    localparam int                         TMO_W     = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1
) (
    input  logic                          sys_clock,
    input  logic                          reset_n,
    input  logic                          cpu_clken,
    input  logic [ADDR_W-1:0]             cpu_addr,
    input  logic                          cpu_rw_n,
    input  logic [DATA_W-1:0]             cpu_dout,
    output logic [DATA_W-1:0]             cpu_din,
    output logic                          cpu_rdy,
    output logic [NUM_SLOTS-1:0]          slot_cs,
    output logic                          slot_we,
    output logic [ADDR_W-1:0]             slot_addr,
    output logic [DATA_W-1:0]             slot_wdata,
    input  logic [NUM_SLOTS*DATA_W-1:0]   slot_rdata,
    input  logic [NUM_SLOTS-1:0]          slot_ack,
    output logic                          ram_cs,
    output logic                          ram_wr,
    input  logic [DATA_W-1:0]             ram_dout,
    output logic                          bus_err,
    input  logic                          bus_err_clr
);

    logic                 dec_hit;
    logic [IDX_W-1:0]     dec_idx;
    logic [NUM_SLOTS-1:0] dec_onehot;

    logic [DATA_W-1:0]    rdata_arr [NUM_SLOTS];
    logic [3:0]           wait_arr  [NUM_SLOTS];
    logic [NUM_SLOTS-1:0] fast_vec;
    logic [NUM_SLOTS-1:0] sel_onehot;

    bus_state_t           state_reg, state_next;
    logic [3:0]           wait_cnt_reg;
    logic [TMO_W-1:0]     tmo_cnt_reg;
    logic [ADDR_W-1:0]    addr_reg;
    logic [DATA_W-1:0]    wdata_reg;
    logic [DATA_W-1:0]    rdata_q;
    logic                 rw_reg;
    logic [IDX_W-1:0]     idx_reg;
    logic                 we_pulse_reg;
    logic                 bus_err_reg;

    logic                 tgt_fast;
    logic                 issue;
    logic                 complete;
    logic                 expire;

    apple1_addr_decode #(
        .NUM_SLOTS (NUM_SLOTS),
        .ADDR_W    (ADDR_W),
        .SLOT_BASE (SLOT_BASE),
        .SLOT_MASK (SLOT_MASK)
    ) u_decode (
        .addr   (cpu_addr),
        .hit    (dec_hit),
        .idx    (dec_idx),
        .onehot (dec_onehot)
    );

    for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
        assign rdata_arr[gi]  = slot_rdata[gi*DATA_W +: DATA_W];
        assign wait_arr[gi]   = slot_wait(FIELD_BUS_W'(SLOT_WAIT), gi);
        assign fast_vec[gi]   = (wait_arr[gi] == 4'd0) && !SLOT_ACK[gi];
        assign sel_onehot[gi] = (idx_reg == IDX_W'(gi));
    end

    assign tgt_fast = !dec_hit || fast_vec[dec_idx];
    assign issue    = (state_reg == ST_IDLE) && !tgt_fast && cpu_clken;
    assign complete = (state_reg == ST_WAIT) && (wait_cnt_reg == 4'd0)
                      && (!SLOT_ACK[idx_reg] || slot_ack[idx_reg]);
    // Completion takes precedence when ack and expiry land in the same cycle.
    assign expire   = (state_reg == ST_WAIT) && !complete && (tmo_cnt_reg <= TMO_W'(1));
    assign bus_err  = bus_err_reg;

    always_comb begin
        state_next = state_reg;
        cpu_rdy    = 1'b0;
        cpu_din    = rdata_q;
        slot_cs    = sel_onehot;
        slot_addr  = addr_reg;
        slot_wdata = wdata_reg;
        slot_we    = we_pulse_reg;
        ram_cs     = 1'b0;
        ram_wr     = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (issue) begin
                    state_next = ST_WAIT;
                end
                // A slow slot is only selected once its access has been latched.
                cpu_rdy    = tgt_fast;
                slot_addr  = cpu_addr;
                slot_wdata = cpu_dout;
                slot_cs    = tgt_fast ? dec_onehot : '0;
                ram_cs     = !dec_hit;
                ram_wr     = !dec_hit && !cpu_rw_n && cpu_clken;
                slot_we    = dec_hit && tgt_fast && !cpu_rw_n && cpu_clken;
                if (!dec_hit) begin
                    cpu_din = ram_dout;
                end else if (tgt_fast) begin
                    cpu_din = rdata_arr[dec_idx];
                end else begin
                    cpu_din = DATA_W'(DATA_IDLE);
                end
            end
            ST_WAIT: begin
                if (complete || expire) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                cpu_rdy = 1'b1;
                if (cpu_clken) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge sys_clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg    <= ST_IDLE;
            wait_cnt_reg <= 4'd0;
            tmo_cnt_reg  <= '0;
            addr_reg     <= '0;
            wdata_reg    <= '0;
            rw_reg       <= 1'b1;
            idx_reg      <= '0;
            rdata_q      <= DATA_W'(DATA_IDLE);
            we_pulse_reg <= 1'b0;
            bus_err_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            we_pulse_reg <= complete && !rw_reg;

            if (issue) begin
                addr_reg     <= cpu_addr;
                wdata_reg    <= cpu_dout;
                rw_reg       <= cpu_rw_n;
                idx_reg      <= dec_idx;
                wait_cnt_reg <= wait_arr[dec_idx];
                tmo_cnt_reg  <= TMO_W'(TIMEOUT);
            end else if (state_reg == ST_WAIT) begin
                if (wait_cnt_reg != 4'd0) begin
                    wait_cnt_reg <= wait_cnt_reg - 4'd1;
                end
                if (tmo_cnt_reg != '0) begin
                    tmo_cnt_reg <= tmo_cnt_reg - TMO_W'(1);
                end
            end

            if (complete) begin
                rdata_q <= rdata_arr[idx_reg];
            end else if (expire) begin
                rdata_q <= DATA_W'(DATA_IDLE);
            end

            // A timeout in the same cycle as a clear request keeps the flag set.
            if (expire) begin
                bus_err_reg <= 1'b1;
            end else if (bus_err_clr) begin
                bus_err_reg <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_apple1_bus_ctrl.sv
// Scoreboard bench for apple1_bus_ctrl: read data and write beats are queued at stimulus time
// and compared when the controller completes them.
module tb_apple1_bus_ctrl;

    localparam int NUM_SLOTS = 4;
    localparam int ADDR_W    = 16;
    localparam int DATA_W    = 8;
    localparam int WR_W      = 1 + NUM_SLOTS + ADDR_W + DATA_W;

    logic                        sys_clock = 1'b0;
    logic                        reset_n;
    logic                        cpu_clken;
    logic [ADDR_W-1:0]           cpu_addr;
    logic                        cpu_rw_n;
    logic [DATA_W-1:0]           cpu_dout;
    logic [DATA_W-1:0]           cpu_din;
    logic                        cpu_rdy;
    logic [NUM_SLOTS-1:0]        slot_cs;
    logic                        slot_we;
    logic [ADDR_W-1:0]           slot_addr;
    logic [DATA_W-1:0]           slot_wdata;
    logic [NUM_SLOTS*DATA_W-1:0] slot_rdata;
    logic [NUM_SLOTS-1:0]        slot_ack;
    logic                        ram_cs;
    logic                        ram_wr;
    logic [DATA_W-1:0]           ram_dout;
    logic                        bus_err;
    logic                        bus_err_clr;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [DATA_W-1:0] rd_q [$];
    logic [WR_W-1:0]   wr_q [$];

    // Slot 1 (0xF000-0xF007) is made an ack slot so the timeout path can be reached.
    apple1_bus_ctrl #(
        .SLOT_ACK (4'b0010)
    ) dut (
        .sys_clock   (sys_clock),
        .reset_n     (reset_n),
        .cpu_clken   (cpu_clken),
        .cpu_addr    (cpu_addr),
        .cpu_rw_n    (cpu_rw_n),
        .cpu_dout    (cpu_dout),
        .cpu_din     (cpu_din),
        .cpu_rdy     (cpu_rdy),
        .slot_cs     (slot_cs),
        .slot_we     (slot_we),
        .slot_addr   (slot_addr),
        .slot_wdata  (slot_wdata),
        .slot_rdata  (slot_rdata),
        .slot_ack    (slot_ack),
        .ram_cs      (ram_cs),
        .ram_wr      (ram_wr),
        .ram_dout    (ram_dout),
        .bus_err     (bus_err),
        .bus_err_clr (bus_err_clr)
    );

    always #5 sys_clock = ~sys_clock;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end else begin
            $display("[TB] ok %s = 0x%0h", tag, got);
        end
    endtask

    // Completion monitor: reads finish on a clken cycle with rdy high, writes on a strobe.
    always @(negedge sys_clock) begin
        if (reset_n === 1'b1) begin
            if (cpu_clken && cpu_rdy && cpu_rw_n) begin
                if (rd_q.size() == 0) check_val("rd_unexpected", 32'(rd_q.size()), 32'd1);
                else                  check_val("rd_data", 32'(cpu_din), 32'(rd_q.pop_front()));
            end
            if (slot_we || ram_wr) begin
                if (wr_q.size() == 0) check_val("wr_unexpected", 32'(wr_q.size()), 32'd1);
                else check_val("wr_beat", 32'({ram_wr, slot_cs, slot_addr, slot_wdata}),
                               32'(wr_q.pop_front()));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge sys_clock);
        #1;
    endtask

    task automatic fast_read(input logic [15:0] a, input logic [7:0] exp,
                             input logic [3:0] exp_cs, input string tag);
        cpu_addr  = a;
        cpu_rw_n  = 1'b1;
        cpu_clken = 1'b1;
        rd_q.push_back(exp);
        @(negedge sys_clock);
        check_val({tag, "_rdy"}, 32'(cpu_rdy), 32'd1);
        check_val({tag, "_cs"}, 32'({ram_cs, slot_cs}), 32'({exp_cs == 4'd0, exp_cs}));
        tick();
        cpu_clken = 1'b0;
    endtask

    task automatic fast_write(input logic [15:0] a, input logic [7:0] d,
                              input logic [3:0] exp_cs, input string tag);
        cpu_addr  = a;
        cpu_dout  = d;
        cpu_rw_n  = 1'b0;
        cpu_clken = 1'b1;
        wr_q.push_back({exp_cs == 4'd0, exp_cs, a, d});
        @(negedge sys_clock);
        check_val({tag, "_rdy"}, 32'(cpu_rdy), 32'd1);
        tick();
        cpu_clken = 1'b0;
        cpu_rw_n  = 1'b1;
    endtask

    task automatic issue_slow(input logic [15:0] a, input logic rw, input logic [7:0] d);
        cpu_addr  = a;
        cpu_rw_n  = rw;
        cpu_dout  = d;
        cpu_clken = 1'b1;
        @(negedge sys_clock);
        check_val("issue_rdy", 32'(cpu_rdy), 32'd0);
        tick();
    endtask

    // Counts WAIT cycles (rdy low) until DONE; raises slot 1 ack during WAIT cycle ack_at.
    task automatic run_slow(input int ack_at, output int n);
        n = 0;
        cpu_clken = 1'b0;
        if (ack_at == 1) slot_ack[1] = 1'b1;
        for (int k = 0; k < 200; k++) begin
            @(negedge sys_clock);
            if (cpu_rdy) break;
            n++;
            tick();
            if (ack_at > 1 && n == ack_at - 1) slot_ack[1] = 1'b1;
        end
    endtask

    task automatic finish_slow();
        tick();
        cpu_clken = 1'b1;
        @(negedge sys_clock);
        tick();
        cpu_clken = 1'b0;
        slot_ack  = '0;
    endtask

    initial begin
        int n;
        reset_n     = 1'b0;
        cpu_clken   = 1'b0;
        cpu_addr    = 16'h1234;
        cpu_rw_n    = 1'b1;
        cpu_dout    = '0;
        slot_rdata  = {8'h85, 8'h22, 8'h4B, 8'h77};
        slot_ack    = '0;
        ram_dout    = 8'h3C;
        bus_err_clr = 1'b0;

        repeat (2) tick();
        @(negedge sys_clock);
        check_val("rst_bus_err", 32'(bus_err), 32'd0);
        check_val("rst_slot_we", 32'(slot_we), 32'd0);
        check_val("rst_slot_cs", 32'(slot_cs), 32'd0);
        check_val("rst_ram_cs", 32'(ram_cs), 32'd1);
        check_val("rst_rdy", 32'(cpu_rdy), 32'd1);
        tick();
        reset_n = 1'b1;
        tick();

        fast_read(16'hD011, 8'h85, 4'b1000, "rd_d011");
        fast_read(16'hD012, 8'h22, 4'b0100, "rd_d012");
        fast_read(16'hD013, 8'h22, 4'b0100, "rd_d013");
        fast_read(16'hD014, 8'h3C, 4'b0000, "rd_d014");
        fast_read(16'hF008, 8'h3C, 4'b0000, "rd_f008");
        fast_read(16'hC100, 8'h3C, 4'b0000, "rd_c100");
        ram_dout = 8'h91;
        fast_read(16'h1234, 8'h91, 4'b0000, "rd_1234");

        fast_write(16'hD010, 8'hA5, 4'b1000, "wr_d010");
        fast_write(16'hD013, 8'h5C, 4'b0100, "wr_d013");
        fast_write(16'h1234, 8'h3C, 4'b0000, "wr_ram");
        cpu_addr = 16'h1234;
        cpu_rw_n = 1'b0;
        @(negedge sys_clock);
        check_val("ram_wr_noclken", 32'(ram_wr), 32'd0);
        tick();
        cpu_addr = 16'hD010;
        @(negedge sys_clock);
        check_val("slot_we_noclken", 32'(slot_we), 32'd0);
        tick();

        wr_q.push_back({1'b0, 4'b0001, 16'hC010, 8'h5A});
        issue_slow(16'hC010, 1'b0, 8'h5A);
        cpu_addr = 16'h1234;
        cpu_dout = 8'h00;
        run_slow(0, n);
        check_val("wr_c010_wait_cycles", 32'(n), 32'd4);
        check_val("wr_c010_done_cs", 32'(slot_cs), 32'b0001);
        finish_slow();
        cpu_rw_n = 1'b1;

        rd_q.push_back(8'h77);
        issue_slow(16'hC020, 1'b1, 8'h00);
        run_slow(0, n);
        check_val("rd_c020_wait_cycles", 32'(n), 32'd4);
        finish_slow();

        rd_q.push_back(8'h4B);
        issue_slow(16'hF001, 1'b1, 8'h00);
        run_slow(1, n);
        check_val("ack_wait_cycles", 32'(n), 32'd1);
        check_val("ack_bus_err", 32'(bus_err), 32'd0);
        finish_slow();

        rd_q.push_back(8'hFF);
        issue_slow(16'hF004, 1'b1, 8'h00);
        run_slow(0, n);
        check_val("tmo_wait_cycles", 32'(n), 32'd64);
        check_val("tmo_bus_err", 32'(bus_err), 32'd1);
        finish_slow();
        check_val("tmo_bus_err_sticky", 32'(bus_err), 32'd1);
        bus_err_clr = 1'b1;
        tick();
        bus_err_clr = 1'b0;
        @(negedge sys_clock);
        check_val("bus_err_cleared", 32'(bus_err), 32'd0);
        tick();

        rd_q.push_back(8'h4B);
        issue_slow(16'hF002, 1'b1, 8'h00);
        run_slow(64, n);
        check_val("ack_tmo_tie_cycles", 32'(n), 32'd64);
        check_val("ack_tmo_tie_bus_err", 32'(bus_err), 32'd0);
        finish_slow();

        rd_q.push_back(8'hFF);
        bus_err_clr = 1'b1;
        issue_slow(16'hF003, 1'b1, 8'h00);
        run_slow(0, n);
        check_val("clr_tmo_tie_bus_err", 32'(bus_err), 32'd1);
        bus_err_clr = 1'b0;
        finish_slow();
        check_val("clr_tmo_tie_sticky", 32'(bus_err), 32'd1);
        bus_err_clr = 1'b1;
        tick();
        bus_err_clr = 1'b0;

        issue_slow(16'hC030, 1'b0, 8'h66);
        cpu_clken = 1'b0;
        tick();
        #2;
        reset_n = 1'b0;
        #1;
        check_val("midwait_rst_cs", 32'(slot_cs), 32'd0);
        check_val("midwait_rst_we", 32'(slot_we), 32'd0);
        cpu_addr = 16'h1234;
        cpu_rw_n = 1'b1;
        #1;
        check_val("midwait_rst_rdy", 32'(cpu_rdy), 32'd1);
        check_val("midwait_rst_ram_cs", 32'(ram_cs), 32'd1);
        tick();
        tick();
        reset_n = 1'b1;
        repeat (6) tick();
        cpu_addr = 16'hC030;
        @(negedge sys_clock);
        check_val("midwait_no_reissue_cs", 32'(slot_cs), 32'd0);
        check_val("midwait_bus_err", 32'(bus_err), 32'd0);
        tick();
        cpu_addr = 16'h1234;
        tick();

        check_val("rd_q_left", 32'(rd_q.size()), 32'd0);
        check_val("wr_q_left", 32'(wr_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
